// File: rtl/chaos_bit_harvester.sv
// chaos_bit_harvester: samples the tinychaos comparator on a programmable tick, packs bits MSB-first into bytes, buffers them in a byte FIFO.
// Latency: comp_in -> first tick that can see it is SYNC_STAGES clocks; completing tick -> FIFO same edge, valid the next cycle.
// Backpressure: none upstream; a byte completed while the FIFO is full (and not popping) is dropped and sets sticky overflow.
// Optional macro CHAOS_VN_DEBIAS_EN: von Neumann debiasing of consecutive tick samples.

// chaos_fifo: generic W-bit FIFO with head-of-queue output, no bypass.
// Latency: a push shows on head_vld the cycle after the write edge; a pop advances the head at the edge.
// Backpressure: push when full is accepted only if a pop happens the same cycle, otherwise flagged on drop.
module chaos_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic         head_vld,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_vld & ~empty;
    assign do_push = push_vld & (~full | do_pop);
    assign drop    = push_vld & full & ~do_pop;

    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];
    assign head_vld = ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

module chaos_bit_harvester #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             comp_in,
    input  logic [DIV_W-1:0] div,
    input  logic             rd,
    output logic [7:0]       data,
    output logic             valid,
    output logic             overflow,
    input  logic             clr_ovf
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [2:0]             bcnt_q, bcnt_d;
    logic                   ovf_q, ovf_d;
    logic                   sample;
    logic                   tick;
    logic                   bit_vld;
    logic                   bit_dat;
    logic                   push_vld;
    logic [7:0]             push_dat;
    logic                   drop;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], comp_in};
    assign sample = sync_q[SYNC_STAGES-1];

    // ">=" rather than "==" so a div shrinking below the count still wraps on the next cycle.
    assign tick = ena && (cnt_q >= div);

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (!ena || tick) begin
            cnt_d = '0;
        end
    end

`ifdef CHAOS_VN_DEBIAS_EN
    logic pair_have_q, pair_have_d;
    logic pair_a_q, pair_a_d;

    always_comb begin
        pair_have_d = pair_have_q;
        pair_a_d    = pair_a_q;
        bit_vld     = 1'b0;
        bit_dat     = pair_a_q;
        if (!ena) begin
            pair_have_d = 1'b0;
            pair_a_d    = 1'b0;
        end else if (tick) begin
            if (!pair_have_q) begin
                pair_have_d = 1'b1;
                pair_a_d    = sample;
            end else begin
                // (1,0) emits 1 and (0,1) emits 0, i.e. the first sample of an unequal pair.
                bit_vld     = (pair_a_q != sample);
                pair_have_d = 1'b0;
                pair_a_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_have_q <= 1'b0;
            pair_a_q    <= 1'b0;
        end else begin
            pair_have_q <= pair_have_d;
            pair_a_q    <= pair_a_d;
        end
    end
`else
    assign bit_vld = tick;
    assign bit_dat = sample;
`endif

    always_comb begin
        shreg_d  = shreg_q;
        bcnt_d   = bcnt_q;
        push_vld = 1'b0;
        push_dat = {shreg_q[6:0], bit_dat};
        if (!ena) begin
            shreg_d = '0;
            bcnt_d  = '0;
        end else if (bit_vld) begin
            shreg_d  = {shreg_q[6:0], bit_dat};
            bcnt_d   = bcnt_q + 3'd1;
            push_vld = (bcnt_q == 3'd7);
        end
    end

    chaos_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (rd),
        .head_dat (data),
        .head_vld (valid),
        .drop     (drop)
    );

    // A drop in the same cycle as clr_ovf keeps the flag set.
    assign ovf_d    = drop | (ovf_q & ~clr_ovf);
    assign overflow = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_chaos_bit_harvester.sv
// Directed-vector bench for chaos_bit_harvester; raw build by default, debias vectors when CHAOS_VN_DEBIAS_EN is defined.
module tb_chaos_bit_harvester;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       comp_in;
    logic [7:0] div;
    logic       rd;
    logic [7:0] data;
    logic       valid;
    logic       overflow;
    logic       clr_ovf;

    int n_vec;
    int n_err;

    chaos_bit_harvester #(
        .SYNC_STAGES (2),
        .DIV_W       (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .comp_in  (comp_in),
        .div      (div),
        .rd       (rd),
        .data     (data),
        .valid    (valid),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ena     = 1'b0;
        comp_in = 1'b0;
        div     = 8'd0;
        rd      = 1'b0;
        clr_ovf = 1'b0;
        steps(2);
        rst_n = 1'b1;
        step();
    endtask

    // Bit j is driven in cycle j; ena rises in cycle 2 so the tick in cycle j+2 samples bit j (div must be 0).
    task automatic run_stream(input logic [63:0] bits, input int n, input logic rd_last, input logic clr_last);
        for (int j = 0; j < n + 2; j++) begin
            comp_in = (j < n) ? bits[n-1-j] : 1'b0;
            ena     = (j >= 2);
            rd      = rd_last  && (j == n + 1);
            clr_ovf = clr_last && (j == n + 1);
            step();
        end
        ena     = 1'b0;
        rd      = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, {31'd0, valid}, 32'd1);
        check(tag, {24'd0, data}, {24'd0, exp});
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        ena     = 1'b0;
        comp_in = 1'b0;
        div     = 8'd0;
        rd      = 1'b0;
        clr_ovf = 1'b0;
        #3;
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        do_reset();

`ifdef CHAOS_VN_DEBIAS_EN
        comp_in = 1'b1;
        steps(3);
        ena = 1'b1;
        steps(100);
        check("vn_const_valid", {31'd0, valid}, 32'd0);
        ena = 1'b0;
        step();
        run_stream(64'hAA55, 16, 1'b0, 1'b0);
        check("vn_pairs_valid", {31'd0, valid}, 32'd1);
        check("vn_pairs_data", {24'd0, data}, 32'hF0);
`else
        // div=0, comp_in=1: eight ticks complete 0xFF
        comp_in = 1'b1;
        steps(3);
        ena = 1'b1;
        steps(7);
        check("ones_valid_early", {31'd0, valid}, 32'd0);
        step();
        check("ones_valid", {31'd0, valid}, 32'd1);
        check("ones_data", {24'd0, data}, 32'hFF);

        // div=3, alternating one value per tick -> 0xAA
        do_reset();
        div = 8'd3;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 4; c++) begin
                comp_in = (k % 2 == 0);
                ena     = 1'b1;
                step();
            end
        end
        check("alt_valid", {31'd0, valid}, 32'd1);
        check("alt_data", {24'd0, data}, 32'hAA);

        // div shrinks below the running count: next cycle is terminal
        do_reset();
        comp_in = 1'b1;
        div     = 8'd7;
        steps(3);
        ena = 1'b1;
        steps(5);
        div = 8'd2;
        steps(21);
        check("divchg_valid_early", {31'd0, valid}, 32'd0);
        step();
        check("divchg_valid", {31'd0, valid}, 32'd1);
        check("divchg_data", {24'd0, data}, 32'hFF);

        // overflow: five bytes into a four-deep FIFO
        do_reset();
        run_stream(64'h11_2233_4455, 40, 1'b0, 1'b0);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_head", {24'd0, data}, 32'h11);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);
        run_stream(64'h66, 8, 1'b1, 1'b0);
        check("full_push_pop_ovf", {31'd0, overflow}, 32'd0);
        run_stream(64'h77, 8, 1'b0, 1'b1);
        check("ovf_set_wins", {31'd0, overflow}, 32'd1);
        pop_expect("pop0", 8'h22);
        pop_expect("pop1", 8'h33);
        pop_expect("pop2", 8'h44);
        pop_expect("pop3", 8'h66);
        check("drained_valid", {31'd0, valid}, 32'd0);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("rd_empty_ignored", {31'd0, valid}, 32'd0);

        // ena drop after 5 bits discards the partial byte
        do_reset();
        comp_in = 1'b1;
        steps(3);
        ena = 1'b1;
        steps(5);
        ena = 1'b0;
        steps(2);
        ena = 1'b1;
        steps(7);
        check("ena_partial_valid", {31'd0, valid}, 32'd0);
        step();
        check("ena_valid", {31'd0, valid}, 32'd1);
        check("ena_data", {24'd0, data}, 32'hFF);

        // asynchronous reset with two bytes buffered
        do_reset();
        run_stream(64'hA55A, 16, 1'b0, 1'b0);
        check("two_valid", {31'd0, valid}, 32'd1);
        check("two_head", {24'd0, data}, 32'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_data", {24'd0, data}, 32'h00);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", {31'd0, valid}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
